// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline stages.
//   NOP_INSTR / HALT_INSTR : special instruction encodings
//   fetch_state_t          : run-control FSM states of the fetch stage
//   OP_*                   : opcode constants shared with the ID-stage branch resolver
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_JUMP = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register.
//   clk, rst      : clock, synchronous active-high reset (pc -> 0)
//   load, load_pc : load pc with load_pc (highest priority after reset)
//   inc           : pc <= pc + 1, modulo 2^PC_WIDE
//   pc            : current program counter
module pc_register
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_WIDE = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PC_WIDE-1:0] load_pc,
  input  logic               inc,
  output logic [PC_WIDE-1:0] pc
);

  logic [PC_WIDE-1:0] pc_q;
  logic [PC_WIDE-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + PC_WIDE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and loads the IF/ID pipeline register. A run-control FSM
// (IDLE/RUN/HALT) supports start, single-step and halt detection.
//   clk, rst            : clock, synchronous active-high reset
//   start               : leave IDLE (pulse)
//   step_mode, step     : single-step control
//   stall               : hazard hold of PC and IF/ID
//   taken, branch_pc    : redirect from the ID-stage branch resolver
//   imem_addr/imem_data : combinational instruction-memory read port
//   if_id_instr/_pc_next/_valid : IF/ID pipeline register
//   halted              : high in HALT
//   instr_count         : valid instructions delivered since reset
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_WIDE    = 7,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               stall,
  input  logic               taken,
  input  logic [PC_WIDE-1:0] branch_pc,
  output logic [PC_WIDE-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        if_id_instr,
  output logic [PC_WIDE-1:0] if_id_pc_next,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        instr_count
);

  fetch_state_t state_q, state_d;

  logic [31:0]        instr_q, instr_d;
  logic [PC_WIDE-1:0] pc_next_q, pc_next_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [31:0]        count_q, count_d;

  logic               pc_load;
  logic               pc_inc;
  logic [PC_WIDE-1:0] pc;
  logic [PC_WIDE-1:0] pc_plus1;
  logic               fe;

  pc_register #(
    .PC_WIDE (PC_WIDE)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (branch_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  assign pc_plus1 = pc + PC_WIDE'(1);
  assign fe       = !step_mode || step;

  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    // default: IF/ID loads a bubble
    instr_d   = NOP_INSTR;
    pc_next_d = '0;
    valid_d   = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stall) begin
          // branch operands are stale during a stall, so a redirect is ignored
          instr_d   = instr_q;
          pc_next_d = pc_next_q;
          valid_d   = valid_q;
        end else if (taken) begin
          pc_load = 1'b1;
        end else if (fe) begin
          pc_inc = 1'b1;
          if (imem_data == HALT_INSTR) begin
            state_d = HALT;
          end else begin
            instr_d   = imem_data;
            pc_next_d = pc_plus1;
            valid_d   = 1'b1;
            count_d   = count_q + 32'd1;
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign imem_addr     = pc;
  assign if_id_instr   = instr_q;
  assign if_id_pc_next = pc_next_q;
  assign if_id_valid   = valid_q;
  assign halted        = halted_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned PW = 7;

  logic          clk;
  logic          rst;
  logic          start;
  logic          step_mode;
  logic          step;
  logic          stall;
  logic          taken;
  logic [PW-1:0] branch_pc;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   if_id_instr;
  logic [PW-1:0] if_id_pc_next;
  logic          if_id_valid;
  logic          halted;
  logic [31:0]   instr_count;

  logic [31:0] mem [0:127];

  int total;
  int bad;

  fetch_stage #(
    .PC_WIDE    (PW),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .step_mode     (step_mode),
    .step          (step),
    .stall         (stall),
    .taken         (taken),
    .branch_pc     (branch_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc_next (if_id_pc_next),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          step_mode;
    logic          step;
    logic          stall;
    logic          taken;
    logic [PW-1:0] bpc;
    logic          e_valid;
    logic [31:0]   e_instr;
    logic [PW-1:0] e_pcn;
    logic [PW-1:0] e_addr;
    logic [31:0]   e_cnt;
    logic          e_halt;
  } vec_t;

  vec_t vecs [0:12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sm, input logic sp,
                       input logic sl, input logic tk, input logic [PW-1:0] bp);
    start = st; step_mode = sm; step = sp; stall = sl; taken = tk; branch_pc = bp;
  endtask

  // pc_next is only meaningful for a valid entry, so it is checked only then
  task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                            input logic [PW-1:0] pcn, input logic [PW-1:0] addr,
                            input logic [31:0] cnt, input logic h);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    chk({tag, ".instr"}, if_id_instr, ins);
    if (v) chk({tag, ".pc_next"}, 32'(if_id_pc_next), 32'(pcn));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, ".count"}, instr_count, cnt);
    chk({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, '0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 128; i++) mem[i] = 32'h100 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    //            st sm sp sl tk bpc    v  instr        pcn    addr   cnt h
    vecs[0]  = '{1, 0, 0, 0, 0, 7'h00, 0, 32'h0,      7'h00, 7'h00, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 7'h00, 1, 32'h11,     7'h01, 7'h01, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 7'h00, 1, 32'h22,     7'h02, 7'h02, 2, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 7'h00, 1, 32'h33,     7'h03, 7'h03, 3, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 7'h40, 1, 32'h33,     7'h03, 7'h03, 3, 0};
    vecs[5]  = '{0, 0, 0, 1, 1, 7'h40, 1, 32'h33,     7'h03, 7'h03, 3, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 7'h00, 1, 32'h44,     7'h04, 7'h04, 4, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 7'h00, 1, 32'h104,    7'h05, 7'h05, 5, 0};
    vecs[8]  = '{0, 0, 0, 0, 1, 7'h10, 0, 32'h0,      7'h00, 7'h10, 5, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 7'h00, 1, 32'h110,    7'h11, 7'h11, 6, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 7'h00, 1, 32'h111,    7'h12, 7'h12, 7, 0};
    vecs[11] = '{0, 0, 1, 0, 0, 7'h00, 1, 32'h112,    7'h13, 7'h13, 8, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 7'h00, 0, 32'h0,      7'h00, 7'h13, 8, 0};

    cyc();
    cyc();
    rst = 1'b0;
    #1;
    expect_out("reset", 0, 32'h0, '0, '0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].start, vecs[i].step_mode, vecs[i].step,
            vecs[i].stall, vecs[i].taken, vecs[i].bpc);
      cyc();
      expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                 vecs[i].e_pcn, vecs[i].e_addr, vecs[i].e_cnt, vecs[i].e_halt);
    end

    // PC wrap at 127
    drive(0, 0, 0, 0, 1, 7'd126);
    cyc();
    expect_out("wrap.redir", 0, 32'h0, '0, 7'd126, 8, 0);
    drive(0, 0, 0, 0, 0, '0);
    cyc();
    expect_out("wrap.126", 1, 32'h17e, 7'd127, 7'd127, 9, 0);
    cyc();
    expect_out("wrap.127", 1, 32'h17f, 7'd0, 7'd0, 10, 0);

    // single-step: three pulses spaced four cycles apart
    begin
      int nvalid;
      logic [31:0] exp_i [0:2];
      exp_i[0] = 32'h11; exp_i[1] = 32'h22; exp_i[2] = 32'h33;
      nvalid = 0;
      for (int k = 0; k < 3; k++) begin
        drive(0, 1, 1, 0, 0, '0);
        cyc();
        if (if_id_valid) nvalid++;
        expect_out($sformatf("step%0d", k), 1, exp_i[k], 7'(k + 1), 7'(k + 1), 32'(11 + k), 0);
        drive(0, 1, 0, 0, 0, '0);
        for (int j = 0; j < 3; j++) begin
          cyc();
          if (if_id_valid) nvalid++;
        end
        expect_out($sformatf("step%0d.gap", k), 0, 32'h0, '0, 7'(k + 1), 32'(11 + k), 0);
      end
      chk("step.valid_entries", 32'(nvalid), 32'd3);
    end

    // halt detection, including a wrong-path halt word that must be ignored
    mem[2] = 32'hFFFF_FFFF;
    do_reset();
    #1;
    expect_out("halt.reset", 0, 32'h0, '0, '0, 0, 0);
    drive(1, 0, 0, 0, 0, '0);
    cyc();
    expect_out("halt.start", 0, 32'h0, '0, 7'd0, 0, 0);
    drive(0, 0, 0, 0, 0, '0);
    cyc();
    expect_out("halt.f0", 1, 32'h11, 7'd1, 7'd1, 1, 0);
    cyc();
    expect_out("halt.f1", 1, 32'h22, 7'd2, 7'd2, 2, 0);
    drive(0, 0, 0, 0, 1, 7'd5);
    cyc();
    expect_out("halt.wrongpath", 0, 32'h0, '0, 7'd5, 2, 0);
    drive(0, 0, 0, 0, 1, 7'd2);
    cyc();
    expect_out("halt.back", 0, 32'h0, '0, 7'd2, 2, 0);
    drive(0, 0, 0, 0, 0, '0);
    cyc();
    expect_out("halt.enter", 0, 32'h0, '0, 7'd3, 2, 1);
    drive(1, 1, 1, 0, 0, '0);
    cyc();
    expect_out("halt.hold1", 0, 32'h0, '0, 7'd3, 2, 1);
    drive(1, 0, 0, 0, 1, 7'd9);
    cyc();
    expect_out("halt.hold2", 0, 32'h0, '0, 7'd3, 2, 1);

    // reset out of HALT together with start: start must be ignored
    drive(1, 0, 0, 0, 0, '0);
    rst = 1'b1;
    cyc();
    expect_out("halt.rst", 0, 32'h0, '0, 7'd0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, '0);
    cyc();
    cyc();
    expect_out("rst_start.idle", 0, 32'h0, '0, 7'd0, 0, 0);

    // reset in the middle of a stall
    drive(1, 0, 0, 0, 0, '0);
    cyc();
    drive(0, 0, 0, 0, 0, '0);
    cyc();
    expect_out("stallrst.f0", 1, 32'h11, 7'd1, 7'd1, 1, 0);
    drive(0, 0, 0, 1, 0, '0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_out("stallrst.rst", 0, 32'h0, '0, 7'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage branch resolver. Owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. Consumes the resolver's `taken`/`branch_pc` redirect and the hazard unit's stall. A small run-control FSM lets the debug unit start, single-step and detect program halt.

## Interface
- `PC_WIDE`, 7, PC width in bits; word-addressed instruction memory.
- `HALT_INSTR`, 32'hFFFF_FFFF, encoding that ends program execution.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse from the debug unit; leaves IDLE.
- `step_mode`  in  1  1 = advance only on `step` pulses; 0 = free-run.
- `step`  in  1  one-cycle pulse; permits one fetch when `step_mode`=1.
- `stall`  in  1  hazard-unit hold of PC and IF/ID.
- `taken`  in  1  redirect request from the ID-stage branch resolver.
- `branch_pc`  in  PC_WIDE  redirect target.
- `imem_addr`  out  PC_WIDE  equals `pc`; combinational read address.
- `imem_data`  in  32  instruction at `imem_addr`, same cycle.
- `if_id_instr`  out  32  registered instruction; 0 (NOP) when bubble.
- `if_id_pc_next`  out  PC_WIDE  registered `pc+1` of that instruction; feeds the resolver's `pc_next`.
- `if_id_valid`  out  1  registered; 0 marks a bubble.
- `halted`  out  1  high in HALT.
- `instr_count`  out  32  instructions delivered with `if_id_valid`=1 since reset.

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: `pc` held at 0, IF/ID loads bubbles; `start` → RUN next cycle.
- RUN: fetch enable `fe` = (`step_mode`=0) or `step`.
- Priority per cycle in RUN: `stall` > `taken` > `fe` > hold.
  - `stall`=1: `pc` and IF/ID hold; `taken` ignored, because branch operands are stale.
  - `taken`=1, `stall`=0: `pc` ← `branch_pc`; IF/ID ← bubble. The wrong-path instruction is discarded, and its halt encoding is not acted on. `step` is consumed.
  - `fe`=1: `pc` ← `pc+1`; IF/ID ← {`imem_data`, `pc+1`, valid=1}; `instr_count` +1. If `imem_data` == `HALT_INSTR`: IF/ID ← bubble instead, no count, next state HALT.
  - `fe`=0: `pc` holds; IF/ID ← bubble, so a stepped instruction drains alone.
- HALT: `pc` frozen; IF/ID loads bubbles; `start`/`step` ignored; exit only via `rst`.
- Arithmetic: `pc+1` is modulo 2^PC_WIDE, so 127 wraps to 0 for the default width. `instr_count` wraps modulo 2^32.

## Timing
- All outputs registered except `imem_addr`.
- Reset values: `pc`=0, `if_id_instr`=0, `if_id_pc_next`=0, `if_id_valid`=0, `halted`=0, `instr_count`=0.
- `rst` overrides everything in the same edge, including mid-stall and mid-HALT.
- Fetch latency: an instruction at `pc` appears on IF/ID one edge after its fetch cycle.
- Redirect: `taken` sampled at edge N; the target instruction is on IF/ID at edge N+1 plus one fetch. Exactly one bubble per taken branch.
- `start` in the same cycle as `rst`: ignored. `start` while already in RUN: no effect.
- `step` with `step_mode`=0: no effect (already free-running).

## Structure
- Shared package `pipeline_pkg`: `NOP_INSTR`=32'h0, `HALT_INSTR`, FSM state encoding `fetch_state_t` {IDLE, RUN, HALT}, opcode constants BEQ/BNE/JUMP shared with the branch resolver.
- One sub-module: `pc_register`.
  - Holds `pc` with load/increment/hold controls and synchronous reset.
  - The FSM, IF/ID register and counter live in `fetch_stage`.

## Test plan
- Reset, `start`, memory words 0..3 = 0x11,0x22,0x33,0x44 → IF/ID shows 0x11/pc_next 1, then 0x22/2, 0x33/3; `instr_count`=3.
- `stall`=1 for 2 cycles with `taken`=1, `branch_pc`=0x40 → `pc` and IF/ID unchanged, no redirect. Release with `taken`=0 → sequential fetch resumes.
- `taken`=1, `branch_pc`=0x10 at `pc`=5 → one bubble (valid=0, instr=0), next valid instr from addr 0x10 with pc_next 0x11.
- `pc`=127 free-run → next `imem_addr`=0, `if_id_pc_next`=0.
- `step_mode`=1, three `step` pulses spaced 4 cycles → exactly 3 valid IF/ID entries, bubbles between, `pc` advances 3.
- Word 2 = 0xFFFF_FFFF → `halted`=1 after fetching addr 2, `pc` stays 3, `instr_count`=2. Further `start` is ignored; `rst` → IDLE with all outputs 0.
